// File: rtl/router_fsm_ctrl.sv
// router_fsm_ctrl : control FSM of the 1x3 packet router.
//   Decodes the destination address in each header byte. Sequences the
//   header, payload and parity loads into the addressed output FIFO.
//   Stalls while that FIFO is full, and waits for a busy destination FIFO
//   to drain before the header is loaded. Raises busy to hold the source.
//
// Optional build macro: ROUTER_FSM_DBG_STATE_EN
//   When defined, the output state_dbg[2:0] exposes the current state encoding.
//
// Ports
//   clock            in   system clock, all state changes on posedge
//   resetn           in   synchronous reset, active high (1 = reset)
//   pkt_valid        in   packet byte valid from the source
//   data_in[1:0]     in   destination address taken from the header (3 = invalid)
//   fifo_full        in   full flag of the currently addressed FIFO
//   fifo_empty_0/1/2 in   empty flags of FIFOs 0..2
//   soft_reset_0/1/2 in   read-timeout soft resets, one per FIFO
//   parity_done      in   parity byte already captured
//   low_packet_valid in   pkt_valid dropped while the FIFO was full
//   write_enb_reg    out  write enable toward the FIFOs
//   detect_add       out  FSM is in DECODE_ADDRESS
//   ld_state         out  FSM is in LOAD_DATA
//   laf_state        out  FSM is in LOAD_AFTER_FULL
//   lfd_state        out  FSM is in LOAD_FIRST_DATA
//   full_state       out  FSM is in FIFO_FULL_STATE
//   rst_int_reg      out  FSM is in CHECK_PARITY_ERROR
//   busy             out  source must hold its data
//   state_dbg[2:0]   out  current state encoding (only with the macro defined)
module router_fsm_ctrl (
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_packet_valid,
   output logic       write_enb_reg,
   output logic       detect_add,
   output logic       ld_state,
   output logic       laf_state,
   output logic       lfd_state,
   output logic       full_state,
   output logic       rst_int_reg,
`ifdef ROUTER_FSM_DBG_STATE_EN
   output logic       busy,
   output logic [2:0] state_dbg
`else
   output logic       busy
`endif
);

   typedef enum logic [2:0] {
      DA  = 3'd0,  // decode address
      LFD = 3'd1,  // load first data (header)
      LD  = 3'd2,  // load data
      LP  = 3'd3,  // load parity
      FFS = 3'd4,  // fifo full stall
      LAF = 3'd5,  // load after full
      WTE = 3'd6,  // wait till empty
      CPE = 3'd7   // check parity error
   } state_t;

   state_t     state, next_state;
   logic [1:0] addr_reg;
   logic       soft_hit;
   logic       hdr_empty;
   logic       addr_empty;

   // Only a timeout on the FIFO that this packet targets aborts the packet.
   assign soft_hit = (soft_reset_0 && addr_reg == 2'd0) ||
                     (soft_reset_1 && addr_reg == 2'd1) ||
                     (soft_reset_2 && addr_reg == 2'd2);

   // The empty flag of the FIFO named by the incoming header.
   always_comb begin
      hdr_empty = 1'b0;
      case (data_in)
         2'd0:    hdr_empty = fifo_empty_0;
         2'd1:    hdr_empty = fifo_empty_1;
         2'd2:    hdr_empty = fifo_empty_2;
         default: hdr_empty = 1'b0;
      endcase
   end

   // The empty flag of the FIFO that holds the latched address.
   always_comb begin
      addr_empty = 1'b0;
      case (addr_reg)
         2'd0:    addr_empty = fifo_empty_0;
         2'd1:    addr_empty = fifo_empty_1;
         2'd2:    addr_empty = fifo_empty_2;
         default: addr_empty = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         state    <= DA;
         addr_reg <= 2'd0;
      end else begin
         state <= next_state;
         if (state == DA && pkt_valid && data_in != 2'd3)
            addr_reg <= data_in;
      end
   end

   always_comb begin
      next_state = state;
      if (soft_hit) begin
         next_state = DA;
      end else begin
         case (state)
            DA: begin
               if (pkt_valid && data_in != 2'd3)
                  next_state = hdr_empty ? LFD : WTE;
            end
            LFD: next_state = LD;
            // A full FIFO outranks end of packet, so no byte is dropped.
            LD: begin
               if (fifo_full)       next_state = FFS;
               else if (!pkt_valid) next_state = LP;
            end
            FFS: if (!fifo_full) next_state = LAF;
            LAF: begin
               if (parity_done)           next_state = DA;
               else if (low_packet_valid) next_state = LP;
               else                       next_state = LD;
            end
            LP:  next_state = CPE;
            CPE: next_state = fifo_full ? FFS : DA;
            WTE: if (addr_empty) next_state = LFD;
            default: next_state = DA;
         endcase
      end
   end

   always_comb begin
      detect_add    = (state == DA);
      lfd_state     = (state == LFD);
      ld_state      = (state == LD);
      laf_state     = (state == LAF);
      full_state    = (state == FFS);
      rst_int_reg   = (state == CPE);
      write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
      busy          = !((state == DA) || (state == LD));
   end

`ifdef ROUTER_FSM_DBG_STATE_EN
   assign state_dbg = state;
`endif

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// tb_router_fsm_ctrl : directed self-checking bench for router_fsm_ctrl.
//   Each check compares this output vector against a hand-derived constant:
//   {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
//    write_enb_reg, busy}
module tb_router_fsm_ctrl;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [1:0] data_in = 2'd0;
   logic       fifo_full = 1'b0;
   logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
   logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
   logic       parity_done = 1'b0;
   logic       low_packet_valid = 1'b0;
   logic       write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
   logic       full_state, rst_int_reg, busy;
`ifdef ROUTER_FSM_DBG_STATE_EN
   logic [2:0] state_dbg;
`endif

   int errors = 0;
   int checks = 0;

   // Expected output vectors, one per state.
   localparam logic [7:0] E_DA  = 8'b1000_0000;
   localparam logic [7:0] E_LFD = 8'b0100_0001;
   localparam logic [7:0] E_LD  = 8'b0010_0010;
   localparam logic [7:0] E_LAF = 8'b0001_0011;
   localparam logic [7:0] E_FFS = 8'b0000_1001;
   localparam logic [7:0] E_CPE = 8'b0000_0101;
   localparam logic [7:0] E_LP  = 8'b0000_0011;
   localparam logic [7:0] E_WTE = 8'b0000_0001;

   router_fsm_ctrl dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0),
      .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
      .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
      .soft_reset_2(soft_reset_2), .parity_done(parity_done),
      .low_packet_valid(low_packet_valid), .write_enb_reg(write_enb_reg),
      .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
      .lfd_state(lfd_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
`ifdef ROUTER_FSM_DBG_STATE_EN
      .busy(busy), .state_dbg(state_dbg)
`else
      .busy(busy)
`endif
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] outs();
      return {detect_add, lfd_state, ld_state, laf_state, full_state,
              rst_int_reg, write_enb_reg, busy};
   endfunction

   // Advance one cycle and sample 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL reset_outs got=%b exp=%b", outs(), E_DA);
      end
`ifdef ROUTER_FSM_DBG_STATE_EN
      checks++;
      if (state_dbg !== 3'd0) begin
         errors++; $display("FAIL reset_dbg got=%0d exp=0", state_dbg);
      end
`endif
      resetn = 1'b0;
      step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL idle_da got=%b exp=%b", outs(), E_DA);
      end
   endtask

   task automatic test_normal_packet();
      pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
      step();
      checks++;
      if (outs() !== E_LFD) begin
         errors++; $display("FAIL norm_lfd got=%b exp=%b", outs(), E_LFD);
      end
      data_in = 2'd0;  // payload byte; the address must not be reloaded
      step();
      checks++;
      if (outs() !== E_LD) begin
         errors++; $display("FAIL norm_ld got=%b exp=%b", outs(), E_LD);
      end
      step();
      checks++;
      if (outs() !== E_LD) begin
         errors++; $display("FAIL norm_ld_hold got=%b exp=%b", outs(), E_LD);
      end
      pkt_valid = 1'b0;
      step();
      checks++;
      if (outs() !== E_LP) begin
         errors++; $display("FAIL norm_lp got=%b exp=%b", outs(), E_LP);
      end
      step();
      checks++;
      if (outs() !== E_CPE) begin
         errors++; $display("FAIL norm_cpe got=%b exp=%b", outs(), E_CPE);
      end
      step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL norm_da got=%b exp=%b", outs(), E_DA);
      end
   endtask

   task automatic test_full_stall();
      pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
      step(); step();
      checks++;
      if (outs() !== E_LD) begin
         errors++; $display("FAIL full_ld got=%b exp=%b", outs(), E_LD);
      end
      fifo_full = 1'b1;
      step();
      checks++;
      if (outs() !== E_FFS) begin
         errors++; $display("FAIL full_ffs got=%b exp=%b", outs(), E_FFS);
      end
      step();
      checks++;
      if (outs() !== E_FFS) begin
         errors++; $display("FAIL full_ffs_hold got=%b exp=%b", outs(), E_FFS);
      end
      fifo_full = 1'b0;
      step();
      checks++;
      if (outs() !== E_LAF) begin
         errors++; $display("FAIL full_laf got=%b exp=%b", outs(), E_LAF);
      end
      pkt_valid = 1'b0; low_packet_valid = 1'b1; parity_done = 1'b0;
      step();
      checks++;
      if (outs() !== E_LP) begin
         errors++; $display("FAIL laf_lp got=%b exp=%b", outs(), E_LP);
      end
      low_packet_valid = 1'b0;
      step();
      checks++;
      if (outs() !== E_CPE) begin
         errors++; $display("FAIL laf_cpe got=%b exp=%b", outs(), E_CPE);
      end
      // CPE with a full FIFO goes back to the stall state.
      fifo_full = 1'b1;
      step();
      checks++;
      if (outs() !== E_FFS) begin
         errors++; $display("FAIL cpe_ffs got=%b exp=%b", outs(), E_FFS);
      end
      fifo_full = 1'b0; parity_done = 1'b1;
      step(); step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL laf_parity_da got=%b exp=%b", outs(), E_DA);
      end
      parity_done = 1'b0;
   endtask

   task automatic test_laf_resume();
      pkt_valid = 1'b1; data_in = 2'd0;
      step(); step();
      fifo_full = 1'b1;
      step();
      fifo_full = 1'b0;
      step();
      checks++;
      if (outs() !== E_LAF) begin
         errors++; $display("FAIL res_laf got=%b exp=%b", outs(), E_LAF);
      end
      step();
      checks++;
      if (outs() !== E_LD) begin
         errors++; $display("FAIL res_ld got=%b exp=%b", outs(), E_LD);
      end
      // A full FIFO and the end of the packet in the same cycle: the full stall wins.
      fifo_full = 1'b1; pkt_valid = 1'b0;
      step();
      checks++;
      if (outs() !== E_FFS) begin
         errors++; $display("FAIL full_prio got=%b exp=%b", outs(), E_FFS);
      end
      fifo_full = 1'b0; parity_done = 1'b1;
      step(); step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL res_da got=%b exp=%b", outs(), E_DA);
      end
      parity_done = 1'b0;
   endtask

   task automatic test_wait_till_empty();
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
      step();
      checks++;
      if (outs() !== E_WTE) begin
         errors++; $display("FAIL wte got=%b exp=%b", outs(), E_WTE);
      end
      data_in = 2'd0;  // the wait must follow the latched address, not data_in
      step();
      checks++;
      if (outs() !== E_WTE) begin
         errors++; $display("FAIL wte_hold got=%b exp=%b", outs(), E_WTE);
      end
      fifo_empty_2 = 1'b1;
      step();
      checks++;
      if (outs() !== E_LFD) begin
         errors++; $display("FAIL wte_lfd got=%b exp=%b", outs(), E_LFD);
      end
      pkt_valid = 1'b0;
      step(); step(); step(); step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL wte_done got=%b exp=%b", outs(), E_DA);
      end
   endtask

   task automatic test_soft_reset();
      pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
      step(); step();
      soft_reset_0 = 1'b1;
      step();
      checks++;
      if (outs() !== E_LD) begin
         errors++; $display("FAIL soft_mismatch got=%b exp=%b", outs(), E_LD);
      end
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
      step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL soft_match got=%b exp=%b", outs(), E_DA);
      end
      soft_reset_1 = 1'b0; pkt_valid = 1'b0;
      step();
      // A soft reset also releases a header that is stuck waiting for an empty FIFO.
      pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
      step();
      pkt_valid = 1'b0; soft_reset_2 = 1'b1;
      step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL soft_wte got=%b exp=%b", outs(), E_DA);
      end
      soft_reset_2 = 1'b0; fifo_empty_2 = 1'b1;
   endtask

   task automatic test_invalid_addr();
      pkt_valid = 1'b1; data_in = 2'd3;
      step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL inv_da got=%b exp=%b", outs(), E_DA);
      end
      step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL inv_da2 got=%b exp=%b", outs(), E_DA);
      end
      pkt_valid = 1'b0;
      step();
      checks++;
      if (outs() !== E_DA) begin
         errors++; $display("FAIL idle_no_valid got=%b exp=%b", outs(), E_DA);
      end
   endtask

   initial begin
      test_reset();
      test_normal_packet();
      test_full_stall();
      test_laf_resume();
      test_wait_till_empty();
      test_soft_reset();
      test_invalid_addr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
